// File: rtl/risc15_pkg.sv
// Shared types and encodings for the multicycle RISC core's LM/SM sequencer.
// Holds the sequencer state enum and the op / direction field encodings.
package risc15_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        REQ,
        WB,
        DONE
    } state_t;

    localparam logic OP_LM    = 1'b0;
    localparam logic OP_SM    = 1'b1;
    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

endpackage

// File: rtl/lmsm_sequencer_if.sv
// Memory req/ack port plus register-file read/write ports of the LM/SM sequencer.
// master = sequencer side, slave = memory / register-file side.
interface lmsm_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int REG_AW = 3
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic [REG_AW-1:0] rf_radd;
    logic [DATA_W-1:0] rf_rdata;
    logic              rf_wen;
    logic [REG_AW-1:0] rf_wadd;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output rf_radd,
        input  rf_rdata,
        output rf_wen, rf_wadd, rf_wdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  rf_radd,
        output rf_rdata,
        input  rf_wen, rf_wadd, rf_wdata
    );
endinterface

// File: rtl/lmsm_prio_enc.sv
// Picks the lowest (ascending) or highest (descending) set bit of a register mask.
// Purely combinational; any=0 and index=0 when the mask is empty.
module lmsm_prio_enc
    import risc15_pkg::*;
#(
    parameter int NREG = 8,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic [NREG-1:0]   mask,
    input  logic              dir,
    output logic [REG_AW-1:0] index,
    output logic              any
);

    // Ascending keeps the first hit; descending keeps overwriting, ending on the highest.
    always_comb begin
        index = '0;
        any   = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (mask[i] && (dir == DIR_DESC || !any)) begin
                index = REG_AW'(i);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// Load/store-multiple engine: walks a register mask, one memory word per selected register.
// Latency start->done: SM 2+2n, LM 2+3n cycles, plus one per memory wait cycle.
// Backpressure: request held stable in REQ until mem_ack; start ignored while busy.
module lmsm_sequencer
    import risc15_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NREG      = 8,
    parameter int ADDR_W    = 16,
    parameter int ADDR_STEP = 1,
    localparam int REG_AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              proc_rst,
    input  logic              start,
    input  logic              op,
    input  logic              dir,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NREG-1:0]   reg_mask,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] final_addr,
    lmsm_sequencer_if.master  bus
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

    state_t            state, state_nx;
    logic              op_q, op_nx;
    logic              dir_q, dir_nx;
    logic [NREG-1:0]   pend_q, pend_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [ADDR_W-1:0] fin_q, fin_nx;
    logic [REG_AW-1:0] cur_q, cur_nx;
    logic [DATA_W-1:0] wdata_q, wdata_nx;
    logic [DATA_W-1:0] rdata_q, rdata_nx;

    logic [REG_AW-1:0] enc_idx;
    logic              enc_any;
    logic [NREG-1:0]   cur_bit;

    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a, input logic d);
        return (d == DIR_DESC) ? a - STEP : a + STEP;
    endfunction

    lmsm_prio_enc #(.NREG(NREG)) u_prio_enc (
        .mask  (pend_q),
        .dir   (dir_q),
        .index (enc_idx),
        .any   (enc_any)
    );

    assign cur_bit = NREG'(1) << cur_q;

    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            state   <= IDLE;
            op_q    <= 1'b0;
            dir_q   <= 1'b0;
            pend_q  <= '0;
            addr_q  <= '0;
            fin_q   <= '0;
            cur_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state   <= state_nx;
            op_q    <= op_nx;
            dir_q   <= dir_nx;
            pend_q  <= pend_nx;
            addr_q  <= addr_nx;
            fin_q   <= fin_nx;
            cur_q   <= cur_nx;
            wdata_q <= wdata_nx;
            rdata_q <= rdata_nx;
        end
    end

    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        dir_nx   = dir_q;
        pend_nx  = pend_q;
        addr_nx  = addr_q;
        fin_nx   = fin_q;
        cur_nx   = cur_q;
        wdata_nx = wdata_q;
        rdata_nx = rdata_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    op_nx    = op;
                    dir_nx   = dir;
                    pend_nx  = reg_mask;
                    // Descending is pre-decrement: the first access is already one step below base.
                    addr_nx  = (dir == DIR_DESC) ? base_addr - STEP : base_addr;
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (!enc_any) begin
                    fin_nx   = (dir_q == DIR_DESC) ? addr_q + STEP : addr_q;
                    state_nx = DONE;
                end else begin
                    cur_nx   = enc_idx;
                    wdata_nx = (op_q == OP_SM) ? bus.rf_rdata : '0;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    if (op_q == OP_SM) begin
                        pend_nx  = pend_q & ~cur_bit;
                        addr_nx  = step_addr(addr_q, dir_q);
                        state_nx = SCAN;
                    end else begin
                        rdata_nx = bus.mem_rdata;
                        state_nx = WB;
                    end
                end
            end
            WB: begin
                pend_nx  = pend_q & ~cur_bit;
                addr_nx  = step_addr(addr_q, dir_q);
                state_nx = SCAN;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Every output is decoded from state registers only, so nothing is combinational from inputs.
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign final_addr    = fin_q;
    assign bus.mem_req   = (state == REQ);
    assign bus.mem_we    = (state == REQ) && (op_q == OP_SM);
    assign bus.mem_addr  = (state == REQ) ? addr_q  : '0;
    assign bus.mem_wdata = (state == REQ) ? wdata_q : '0;
    assign bus.rf_radd   = enc_idx;
    assign bus.rf_wen    = (state == WB);
    assign bus.rf_wadd   = (state == WB) ? cur_q   : '0;
    assign bus.rf_wdata  = (state == WB) ? rdata_q : '0;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: memory/RF models with a scoreboard of expected
// memory accesses and register writes, plus latency, final address and reset checks.
module tb_lmsm_sequencer;
    import risc15_pkg::*;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] data;
    } rf_exp_t;

    logic        clk;
    logic        proc_rst;
    logic        start;
    logic        op;
    logic        dir;
    logic [15:0] base_addr;
    logic [7:0]  reg_mask;
    logic        busy;
    logic        done;
    logic [15:0] final_addr;

    lmsm_sequencer_if #(.DATA_W(16), .ADDR_W(16), .REG_AW(3)) bus ();

    lmsm_sequencer #(.DATA_W(16), .NREG(8), .ADDR_W(16), .ADDR_STEP(1)) dut (
        .clk        (clk),
        .proc_rst   (proc_rst),
        .start      (start),
        .op         (op),
        .dir        (dir),
        .base_addr  (base_addr),
        .reg_mask   (reg_mask),
        .busy       (busy),
        .done       (done),
        .final_addr (final_addr),
        .bus        (bus)
    );

    int errors = 0;
    int checks = 0;

    mem_exp_t mem_q[$];
    rf_exp_t  rf_q[$];

    logic [15:0] rf_mem [8];
    logic        ack_r = 1'b0;
    logic        stray_ack = 1'b0;
    logic [15:0] rdata_r = '0;
    int          ack_delay = 0;
    int          wcnt = 0;
    bit          sb_off = 1'b0;
    logic        h_we;
    logic [15:0] h_addr, h_wdata;

    assign bus.mem_ack   = ack_r | stray_ack;
    assign bus.mem_rdata = rdata_r;
    assign bus.rf_rdata  = rf_mem[bus.rf_radd];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model: acks after ack_delay wait cycles, returns 0x1000+addr, checks request stability.
    always @(negedge clk) begin
        if (!proc_rst) begin
            ack_r = 1'b0;
            wcnt  = 0;
        end else if (ack_r) begin
            ack_r = 1'b0;
            wcnt  = 0;
        end else if (bus.mem_req) begin
            if (wcnt == 0) begin
                h_we    = bus.mem_we;
                h_addr  = bus.mem_addr;
                h_wdata = bus.mem_wdata;
            end else begin
                chk("hold_we", bus.mem_we, h_we);
                chk("hold_addr", bus.mem_addr, h_addr);
                chk("hold_wdata", bus.mem_wdata, h_wdata);
            end
            if (wcnt >= ack_delay) begin
                ack_r   = 1'b1;
                rdata_r = 16'h1000 + bus.mem_addr;
                if (!sb_off) begin
                    if (mem_q.size() == 0) begin
                        chk("mem_unexpected", 1, 0);
                    end else begin
                        mem_exp_t e;
                        e = mem_q.pop_front();
                        chk("mem_we", bus.mem_we, e.we);
                        chk("mem_addr", bus.mem_addr, e.addr);
                        chk("mem_wdata", bus.mem_wdata, e.wdata);
                    end
                end
            end else begin
                wcnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (proc_rst && bus.rf_wen && !sb_off) begin
            if (rf_q.size() == 0) begin
                chk("rf_unexpected", 1, 0);
            end else begin
                rf_exp_t r;
                r = rf_q.pop_front();
                chk("rf_wadd", bus.rf_wadd, r.idx);
                chk("rf_wdata", bus.rf_wdata, r.data);
            end
        end
    end

    task automatic push_expect(input logic o, input logic d, input logic [15:0] base,
                               input logic [7:0] mask);
        logic [15:0] a;
        a = d ? base - 16'd1 : base;
        for (int k = 0; k < 8; k++) begin
            int i;
            i = d ? 7 - k : k;
            if (mask[i]) begin
                if (o == OP_SM) begin
                    mem_q.push_back('{we: 1'b1, addr: a, wdata: rf_mem[i]});
                end else begin
                    mem_q.push_back('{we: 1'b0, addr: a, wdata: 16'h0000});
                    rf_q.push_back('{idx: 3'(i), data: 16'h1000 + a});
                end
                a = d ? a - 16'd1 : a + 16'd1;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic o, input logic d, input logic [15:0] base,
                          input logic [7:0] mask, input int dly, input int exp_cyc,
                          input logic [15:0] exp_fin, input bit poke);
        int cyc;
        bit got;
        push_expect(o, d, base, mask);
        ack_delay = dly;
        @(posedge clk);
        #1;
        start = 1'b1; op = o; dir = d; base_addr = base; reg_mask = mask;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            start = 1'b0;
            if (poke && cyc == 2) begin
                start = 1'b1; op = ~o; reg_mask = 8'hFF; base_addr = 16'h7777;
            end
            @(negedge clk);
            if (cyc == 1) chk({tag, "_busy"}, busy, 1);
            got = done;
        end
        chk({tag, "_latency"}, cyc, exp_cyc);
        chk({tag, "_final"}, final_addr, exp_fin);
        chk({tag, "_mem_left"}, mem_q.size(), 0);
        chk({tag, "_rf_left"}, rf_q.size(), 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {done, busy}, 0);
        chk({tag, "_final_hold"}, final_addr, exp_fin);
        mem_q.delete();
        rf_q.delete();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) rf_mem[i] = 16'hC000 + 16'(i);
        proc_rst = 1'b1; start = 1'b0; op = 1'b0; dir = 1'b0; base_addr = '0; reg_mask = '0;
        #2 proc_rst = 1'b0;
        #1;
        chk("reset_ctl", {busy, done, bus.mem_req, bus.mem_we, bus.rf_wen}, 0);
        chk("reset_final", final_addr, 0);
        chk("reset_mem_addr", bus.mem_addr, 0);
        repeat (2) @(posedge clk);
        #1 proc_rst = 1'b1;

        run_op("lm_asc_a5", OP_LM, DIR_ASC, 16'h0010, 8'hA5, 0, 14, 16'h0014, 1'b0);
        run_op("sm_desc_81", OP_SM, DIR_DESC, 16'h0020, 8'h81, 0, 6, 16'h001E, 1'b0);
        run_op("mask0", OP_LM, DIR_ASC, 16'h0033, 8'h00, 0, 2, 16'h0033, 1'b0);
        run_op("sm_wait", OP_SM, DIR_ASC, 16'h0060, 8'h02, 3, 7, 16'h0061, 1'b1);
        run_op("lm_wrap", OP_LM, DIR_ASC, 16'hFFFF, 8'h03, 0, 8, 16'h0001, 1'b0);
        run_op("lm_desc_18", OP_LM, DIR_DESC, 16'h0100, 8'h18, 1, 10, 16'h00FE, 1'b0);

        // Stray ack while idle must not start anything.
        @(posedge clk);
        #1 stray_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 stray_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_idle", {busy, bus.mem_req, bus.rf_wen}, 0);

        // Reset in the middle of a 4-register LM.
        sb_off = 1'b1;
        ack_delay = 3;
        @(posedge clk);
        #1;
        start = 1'b1; op = OP_LM; dir = DIR_ASC; base_addr = 16'h0050; reg_mask = 8'h0F;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!bus.mem_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_reached_req", bus.mem_req, 1);
        #2 proc_rst = 1'b0;
        #1;
        chk("rst_async_ctl", {busy, done, bus.mem_req, bus.mem_we, bus.rf_wen}, 0);
        chk("rst_async_addr", bus.mem_addr, 0);
        chk("rst_async_rf", {bus.rf_wadd, bus.rf_wdata, bus.rf_radd}, 0);
        chk("rst_async_final", final_addr, 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_quiet", {busy, bus.mem_req, bus.rf_wen}, 0);
        end
        @(posedge clk);
        #1 proc_rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_quiet", {busy, bus.mem_req, bus.rf_wen}, 0);
        end
        sb_off = 1'b0;
        run_op("sm_after_rst", OP_SM, DIR_ASC, 16'h0040, 8'h01, 0, 4, 16'h0041, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
- Parametrised load-multiple/store-multiple engine for the multicycle RISC core.
- Takes over from the controller's fixed 3-bit LM/SM counter and write-address logic.
- Given a base address and a register bitmask, it walks the selected registers in order. Supports ascending (post-increment) and descending (pre-decrement, push/pop) modes.
- Talks to memory over a req/ack handshake with wait states, and to the register file through a read port and a write port.
- Sits beside the controller; the controller pulses start and waits for done.

Parameters:
- DATA_W, 16, data word width
- NREG, 8, register count and mask width
- ADDR_W, 16, memory address width
- ADDR_STEP, 1, address increment per transferred word
- REG_AW, $clog2(NREG), register index width (derived; do not override)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- proc_rst  in  1  asynchronous, active-low reset
- start  in  1  launch request; sampled only in IDLE
- op  in  1  0 = LM (mem->RF), 1 = SM (RF->mem)
- dir  in  1  0 = ascending, 1 = descending
- base_addr  in  ADDR_W  start address
- reg_mask  in  NREG  bit i set = transfer register i
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- final_addr  out  ADDR_W  address after the last access; held from done until the next start
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  request accepted / read data valid
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- rf_radd  out  REG_AW  RF read address (RF read is combinational)
- rf_rdata  in  DATA_W  RF read data
- rf_wen  out  1  RF write enable
- rf_wadd  out  REG_AW  RF write address
- rf_wdata  out  DATA_W  RF write data

Behaviour:
- Reset (proc_rst low, asynchronous): state IDLE; all outputs 0, including final_addr. Pending mask and address registers clear. An operation in progress is abandoned, with no further rf_wen or mem_req.
- IDLE, start=1:
  - latch op, dir and reg_mask into the pending mask.
  - address register = base_addr (ascending) or base_addr-ADDR_STEP (descending).
  - go to SCAN.
  - start is ignored in every other state.
- SCAN: the priority encoder picks the lowest set pending bit (ascending) or the highest (descending).
  - Pending = 0: go to DONE.
  - Otherwise cur_reg = the selected index and rf_radd = cur_reg. For SM, register rf_rdata into the wdata register. Go to REQ.
- REQ: mem_req=1, mem_we=op, mem_addr = address register, mem_wdata = wdata register (0 for LM).
  - mem_req, mem_addr, mem_we and mem_wdata stay stable until mem_ack.
  - On mem_ack with SM: clear the cur_reg bit, step the address, go to SCAN.
  - On mem_ack with LM: register mem_rdata, go to WB.
- WB (LM only): for one cycle rf_wen=1, rf_wadd=cur_reg, rf_wdata = the captured data. Clear the cur_reg bit, step the address, go to SCAN.
- Address step: ascending = address+ADDR_STEP; descending = address-ADDR_STEP. Both are modulo 2^ADDR_W (silent wrap).
- DONE: done=1 for exactly one cycle. final_addr = address register (ascending) or address register + ADDR_STEP (descending), so final_addr equals base ± n·ADDR_STEP. Then go to IDLE.
- mem_ack while mem_req=0 is ignored.
- Latency with zero-wait ack, n selected registers:
  - SM: start edge -> done high after 2 + 2n cycles.
  - LM: start edge -> done high after 2 + 3n cycles.
  - Each ack wait cycle adds 1.
- The whole block uses registered outputs only; there are no combinational paths from inputs to outputs.

Decomposition:
- Package risc15_pkg holds:
  - state enum {IDLE, SCAN, REQ, WB, DONE}
  - OP_LM/OP_SM and DIR_ASC/DIR_DESC constants
- Sub-module lmsm_prio_enc is parametrised on NREG:
  - inputs: mask, dir
  - outputs: index (REG_AW), any (1)
  - purely combinational

Test Plan:
- LM asc, mask 8'hA5, base 0x0010, mem returns 0x1000+addr with zero wait -> rf writes in order R0=0x1010, R2=0x1011, R5=0x1012, R7=0x1013; done at cycle 14; final_addr=0x0014.
- SM desc, mask 8'h81, base 0x0020 -> writes R7 data @0x001F, then R0 data @0x001E; done at cycle 6; final_addr=0x001E.
- Mask 0 -> no mem_req, no rf_wen; done at cycle 2; final_addr=base.
- SM, mask 8'h02, ack delayed 3 cycles -> mem_req/addr/wdata held stable for 4 cycles; exactly one write; start pulsed while busy is ignored.
- LM asc, base 0xFFFF, mask 8'h03 -> reads 0xFFFF then 0x0000; final_addr=0x0001.
- proc_rst low during REQ of a 4-register LM -> all outputs 0 immediately, no further rf_wen. After release, a new SM (mask 8'h01, base 0x0040) completes normally.
